// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Responder end of the CPU load/store port: a 32-bit word memory reached over
//   a Req/Ack handshake. One request is accepted at a time. It completes after
//   LATENCY cycles. Misaligned byte addresses are flagged instead of accessed.
//
// Handshake: the initiator raises Req and holds it, with WE/Address/DataIn
//   stable, until it sees Ack. A request is accepted only on a rising edge
//   where the FSM is IDLE and Req=1. The acceptance edge is t0. Ack is then a
//   one-cycle pulse that is sampled high at edge t0+LATENCY. Req seen while
//   the FSM is busy (WAIT or RESP) is ignored.
//
// Ports
//   CLK         in   clock, rising edge
//   RST         in   synchronous active-high reset
//   Req         in   request valid
//   WE          in   1 = store, 0 = load
//   Address     in   byte address; word index = Address[ADDR_W+1:2]
//   DataIn      in   store data
//   DataOut     out  load data; updated only by an aligned read
//   Ack         out  one-cycle completion pulse
//   Busy        out  high from the cycle after acceptance through the Ack cycle
//   AddrErr     out  high with Ack when the accepted address was misaligned
//   dbg_state_o out  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req,
    input  logic        WE,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ack,
    output logic        Busy,
    output logic        AddrErr,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic                mis_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic [31:0]         dout_q;
    logic                ack_q;
    logic                busy_q;
    logic                err_q;

    logic [31:0]         mem [DEPTH];

    // Request fields as seen on the edge that enters RESP. With LATENCY=1 that
    // edge is also the acceptance edge, so the live inputs are used in IDLE.
    logic                we_d;
    logic                mis_d;
    logic [ADDR_W-1:0]   idx_d;
    logic [31:0]         wdata_d;
    logic                in_idle;
    logic                enter_resp;

    // Address bits above the word index are ignored (index wraps).
    logic                unused_addr_hi;
    assign unused_addr_hi = ^Address[31:ADDR_W+2];

    always_comb begin
        in_idle = (state_q == S_IDLE);
        we_d    = we_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        if (in_idle) begin
            we_d    = WE;
            mis_d   = (Address[1:0] != 2'b00);
            idx_d   = Address[ADDR_W+1:2];
            wdata_d = DataIn;
        end
        enter_resp = (in_idle && Req && (LATENCY == 1))
                   || ((state_q == S_WAIT) && (cnt_q == 4'd1));
    end

    // Array write on the edge entering RESP. A reset in WAIT therefore drops
    // the store before it reaches the array.
    always_ff @(posedge CLK) begin
        if (!RST && enter_resp && we_d && !mis_d) begin
            mem[idx_d] <= wdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Req) begin
                        we_q    <= we_d;
                        mis_q   <= mis_d;
                        idx_q   <= idx_d;
                        wdata_q <= wdata_d;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        cnt_q   <= '0;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // RESP is the Ack cycle: load data and raise the status outputs
            // on the edge that enters it.
            if (enter_resp) begin
                ack_q <= 1'b1;
                err_q <= mis_d;
                if (!we_d && !mis_d) begin
                    dout_q <= mem[idx_d];
                end
            end
        end
    end

    assign DataOut     = dout_q;
    assign Ack         = ack_q;
    assign Busy        = busy_q;
    assign AddrErr     = err_q;
    assign dbg_state_o = state_q;

endmodule
